// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the EX stage (RV32M ops).
// Ports: CLK, RESET (sync, low), START/OP/DATA1/DATA2/KILL in; BUSY/RESULT_VALID/RESULT out.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic             KILL,
  output logic             BUSY,
  output logic             RESULT_VALID,
  output logic [WIDTH-1:0] RESULT
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   res_q, res_d;

  logic               sgn1, sgn2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic               zero_div, ovf;
  logic [WIDTH-1:0]   spec_res;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   fin_res;

  // Operand decode at accept
  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    unique case (OP)
      3'd1, 3'd4, 3'd6: begin
        sgn1 = DATA1[WIDTH-1];
        sgn2 = DATA2[WIDTH-1];
      end
      3'd2: sgn1 = DATA1[WIDTH-1];
      default: ;
    endcase
    mag1 = sgn1 ? -DATA1 : DATA1;
    mag2 = sgn2 ? -DATA2 : DATA2;
    zero_div = OP[2] && (DATA2 == '0);
    ovf = (OP == 3'd4 || OP == 3'd6) &&
          (DATA1 == MIN_NEG) && (DATA2 == '1);
    spec_res = '0;
    if (zero_div)
      spec_res = OP[1] ? DATA1 : '1;
    else if (ovf)
      spec_res = OP[1] ? '0 : DATA1;
  end

  // One datapath step; acc holds {hi, lo}
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
    mul_step = acc_q[0] ?
      {mul_sum, acc_q[WIDTH-1:1]} :
      {1'b0, acc_q[2*WIDTH-1:1]};
    // Remainder is {hi, next dividend bit}, WIDTH+1 bits wide
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]}
              - {1'b0, a_q};
    div_step = div_trial[WIDTH] ?
      {acc_q[2*WIDTH-2:0], 1'b0} :
      {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    step = op_q[2] ? div_step : mul_step;
    prod = neg_q ? -step : step;
    quo = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    rem = neg_q ? -step[2*WIDTH-1:WIDTH]
                : step[2*WIDTH-1:WIDTH];
    if (op_q[2])
      fin_res = op_q[1] ? rem : quo;
    else if (op_q[1:0] == 2'd0)
      fin_res = prod[WIDTH-1:0];
    else
      fin_res = prod[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (START && !KILL) begin
          op_d  = OP;
          cnt_d = '0;
          // Remainder follows the dividend sign
          neg_d = (OP[2] && OP[1]) ? sgn1 : (sgn1 ^ sgn2);
          if (zero_div || ovf) begin
            state_d = DONE;
            res_d   = spec_res;
          end else begin
            state_d = CALC;
            a_d     = OP[2] ? mag2 : mag1;
            acc_d   = OP[2] ? {{WIDTH{1'b0}}, mag1}
                            : {{WIDTH{1'b0}}, mag2};
          end
        end
      end
      CALC: begin
        if (KILL) begin
          state_d = IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) begin
            state_d = DONE;
            res_d   = fin_res;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  assign BUSY         = (state_q != IDLE);
  assign RESULT_VALID = (state_q == DONE);
  assign RESULT       = res_q;

endmodule
